// File: rtl/alien_laser_ctrl.sv
// alien_laser_ctrl: allocates, advances and retires the three alien laser slots.
module alien_laser_ctrl #(
    parameter logic [9:0] STEP     = 10'd4,
    parameter logic [9:0] Y_LIMIT  = 10'd480,
    parameter logic [7:0] COOLDOWN = 8'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        tick,
    input  logic        fireReq,
    input  logic [9:0]  fireX,
    input  logic [9:0]  fireY,
    input  logic [2:0]  alienLaserHit,
    input  logic [2:0]  shipHit,
    output logic [29:0] alienLaserXcoord,
    output logic [29:0] alienLaserYcoord,
    output logic [2:0]  laserActive,
    output logic        fireAck
);
    typedef enum logic {IDLE, LIVE} slot_e;
    slot_e       st_q [3];
    slot_e       st_d [3];
    logic [9:0]  x_q [3];
    logic [9:0]  x_d [3];
    logic [9:0]  y_q [3];
    logic [9:0]  y_d [3];
    logic [10:0] sum [3];
    logic [7:0]  cd_q, cd_d;
    logic        ack_q;
    logic [2:0]  free, spawn, retire;
    logic        accept;
    always_comb begin
        for (int i = 0; i < 3; i++) free[i] = st_q[i] == IDLE;
        accept = fireReq && cd_q == 8'd0 && |free;
        // lowest set bit of free picks the spawn slot
        spawn = {3{accept}} & free & (~free + 3'd1);
        retire = 3'b000;
        for (int i = 0; i < 3; i++) begin
            sum[i] = {1'b0, y_q[i]} + {1'b0, STEP};
            retire[i] = st_q[i] == LIVE && (alienLaserHit[i] || shipHit[i] || (tick && sum[i] >= {1'b0, Y_LIMIT}));
            st_d[i] = spawn[i] ? LIVE : retire[i] ? IDLE : st_q[i];
            x_d[i] = spawn[i] ? fireX : retire[i] ? 10'd0 : x_q[i];
            y_d[i] = spawn[i] ? fireY : retire[i] ? 10'd0 : (st_q[i] == LIVE && tick) ? sum[i][9:0] : y_q[i];
        end
        cd_d = accept ? COOLDOWN : (tick && cd_q != 8'd0) ? cd_q - 8'd1 : cd_q;
    end
    always_ff @(posedge clk) begin
        if (rst || !mode) begin
            for (int i = 0; i < 3; i++) begin
                st_q[i] <= IDLE;
                x_q[i]  <= 10'd0;
                y_q[i]  <= 10'd0;
            end
            cd_q  <= 8'd0;
            ack_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                st_q[i] <= st_d[i];
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
            end
            cd_q  <= cd_d;
            ack_q <= accept;
        end
    end
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            alienLaserXcoord[i*10 +: 10] = x_q[i];
            alienLaserYcoord[i*10 +: 10] = y_q[i];
            laserActive[i] = st_q[i] == LIVE;
        end
        fireAck = ack_q;
    end
endmodule
